// File: rtl/serial_subtractor.sv
//----------------------------------------------------------------------------
// Module      : serial_subtractor
// Description : Bit-serial two's-complement subtractor. Computes a - b one
//               bit per clock, LSB first, and reports the difference, the
//               final unsigned borrow and the signed overflow flag.
// Revision    : 1.0 - initial release
//----------------------------------------------------------------------------
`default_nettype none

module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out,
  output logic             overflow
);

  // Counter wide enough to hold 0..WIDTH
  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] c_LAST_BIT = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] c_CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_res;
  logic [CNT_W-1:0] r_cnt;
  logic             r_bin;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_diff;
  logic             r_borrow;
  logic             r_ovf;

  logic             w_ai;
  logic             w_bi;
  logic             w_d;
  logic             w_bout;
  logic             w_ovf;
  logic [WIDTH-1:0] w_res_next;

  // One full-subtractor cell operating on the current LSBs of the operands
  assign w_ai       = r_a[0];
  assign w_bi       = r_b[0];
  assign w_d        = w_ai ^ w_bi ^ r_bin;
  assign w_bout     = (~w_ai & w_bi) | (~(w_ai ^ w_bi) & r_bin);
  assign w_res_next = {w_d, r_res[WIDTH-1:1]};
  // On the last bit the operand bits are the sign bits and w_d is the
  // result sign bit, so overflow falls out without keeping copies of a/b
  assign w_ovf      = (w_ai ^ w_bi) & (w_d ^ w_ai);

  // Control FSM, datapath shift registers and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_a      <= '0;
      r_b      <= '0;
      r_res    <= '0;
      r_cnt    <= '0;
      r_bin    <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_diff   <= '0;
      r_borrow <= 1'b0;
      r_ovf    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_a     <= a;
            r_b     <= b;
            r_res   <= '0;
            r_bin   <= 1'b0;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          r_a   <= r_a >> 1;
          r_b   <= r_b >> 1;
          r_res <= w_res_next;
          r_bin <= w_bout;
          r_cnt <= r_cnt + c_CNT_ONE;
          // Outputs are only written here, so partial shifts never show on diff
          if (r_cnt == c_LAST_BIT) begin
            r_state  <= S_DONE;
            r_done   <= 1'b1;
            r_diff   <= w_res_next;
            r_borrow <= w_bout;
            r_ovf    <= w_ovf;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign busy       = r_busy;
  assign done       = r_done;
  assign diff       = r_diff;
  assign borrow_out = r_borrow;
  assign overflow   = r_ovf;

endmodule

`default_nettype wire

// File: tb/tb_serial_subtractor.sv
//----------------------------------------------------------------------------
// Module      : tb_serial_subtractor
// Description : Self-checking bench for serial_subtractor with a
//               cycle-level arithmetic reference model.
// Revision    : 1.0 - initial release
//----------------------------------------------------------------------------
`default_nettype none

module tb_serial_subtractor;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         borrow_out;
  logic         overflow;

  int n_checks = 0;
  int n_fail   = 0;
  bit cmp_en   = 1'b0;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .a          (a),
    .b          (b),
    .busy       (busy),
    .done       (done),
    .diff       (diff),
    .borrow_out (borrow_out),
    .overflow   (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: an operation occupies WIDTH+1 busy cycles after the
  // accepting edge; the result is the plain arithmetic difference.
  int           m_left = 0;
  logic [W-1:0] m_pd   = '0;
  logic         m_pb   = 1'b0;
  logic         m_po   = 1'b0;
  logic [W-1:0] m_diff = '0;
  logic         m_bo   = 1'b0;
  logic         m_ov   = 1'b0;

  function automatic logic signed_ovf(input logic [W-1:0] x, input logic [W-1:0] y);
    int r;
    r = int'($signed(x)) - int'($signed(y));
    return (r > (2 ** (W - 1)) - 1) || (r < -(2 ** (W - 1)));
  endfunction

  // Model update on every clock edge, cleared by asynchronous reset
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_left <= 0;
      m_diff <= '0;
      m_bo   <= 1'b0;
      m_ov   <= 1'b0;
    end else if (m_left == 0) begin
      if (start) begin
        m_left <= W + 1;
        m_pd   <= W'(a - b);
        m_pb   <= (a < b);
        m_po   <= signed_ovf(a, b);
      end
    end else begin
      m_left <= m_left - 1;
      if (m_left == 2) begin
        m_diff <= m_pd;
        m_bo   <= m_pb;
        m_ov   <= m_po;
      end
    end
  end

  // Cycle-by-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("busy", 32'(busy), 32'(m_left != 0));
      chk("done", 32'(done), 32'(m_left == 1));
      chk("diff", 32'(diff), 32'(m_diff));
      chk("borrow_out", 32'(borrow_out), 32'(m_bo));
      chk("overflow", 32'(overflow), 32'(m_ov));
    end
  end

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 5))
      0:       return '0;
      1:       return 8'h80;
      2:       return 8'h7F;
      3:       return 8'hFF;
      default: return W'($urandom);
    endcase
  endfunction

  // Directed operation with literal expectations; optionally scribbles on
  // start/a/b during the run to show they are ignored
  task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                       input logic [W-1:0] ed, input logic eb, input logic eo,
                       input bit junk);
    int n;
    int nb;
    int nd;
    bit found;
    @(negedge clk);
    start = 1'b1;
    a     = ta;
    b     = tb_v;
    @(posedge clk);
    found = 1'b0;
    nb    = 0;
    for (n = 0; n < 30; n++) begin
      @(negedge clk);
      if (busy) nb++;
      if (done) begin
        found = 1'b1;
        break;
      end
      if (junk && n < 4) begin
        start = 1'b1;
        a     = W'($urandom);
        b     = W'($urandom);
      end else begin
        start = 1'b0;
        a     = W'($urandom);
        b     = W'($urandom);
      end
    end
    start = 1'b0;
    chk("done_timeout", 32'(found), 32'd1);
    chk("latency", 32'(n), 32'(W));
    chk("busy_cycles", 32'(nb), 32'(W + 1));
    chk("lit_diff", 32'(diff), 32'(ed));
    chk("lit_borrow", 32'(borrow_out), 32'(eb));
    chk("lit_overflow", 32'(overflow), 32'(eo));
    chk("model_diff", 32'(m_diff), 32'(ed));
    chk("model_borrow", 32'(m_bo), 32'(eb));
    chk("model_overflow", 32'(m_ov), 32'(eo));
    nd = 0;
    repeat (4) begin
      @(negedge clk);
      if (done) nd++;
    end
    chk("done_single", 32'(nd), 32'd0);
  endtask

  initial begin
    int t0;
    int t1;
    int nd;
    int cyc;
    bit ok;

    rst_n = 1'b1;
    start = 1'b0;
    a     = '0;
    b     = '0;
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_diff", 32'(diff), 32'd0);
    chk("rst_borrow", 32'(borrow_out), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    cmp_en = 1'b1;

    do_op(8'd100, 8'd37, 8'd63, 1'b0, 1'b0, 1'b0);
    do_op(8'd5, 8'd10, 8'hFB, 1'b1, 1'b0, 1'b0);
    do_op(8'h80, 8'h01, 8'h7F, 1'b0, 1'b1, 1'b0);
    do_op(8'h7F, 8'hFF, 8'h80, 1'b1, 1'b1, 1'b0);
    do_op(8'h3C, 8'h3C, 8'h00, 1'b0, 1'b0, 1'b0);
    do_op(8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
    // start and operands toggled during RUN
    do_op(8'd77, 8'd12, 8'd65, 1'b0, 1'b0, 1'b1);

    // Asynchronous reset in the 4th RUN cycle
    @(negedge clk);
    start = 1'b1;
    a     = 8'd90;
    b     = 8'd3;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_diff", 32'(diff), 32'd0);
    chk("abort_borrow", 32'(borrow_out), 32'd0);
    chk("abort_overflow", 32'(overflow), 32'd0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    nd = 0;
    repeat (12) begin
      @(negedge clk);
      if (done) nd++;
    end
    chk("abort_no_done", 32'(nd), 32'd0);
    do_op(8'd200, 8'd55, 8'd145, 1'b0, 1'b0, 1'b0);

    // Randomized traffic checked by the model
    for (int i = 0; i < 300; i++) begin
      @(posedge clk);
      #1;
      start = ($urandom_range(0, 3) == 0);
      a     = pick();
      b     = pick();
    end
    @(posedge clk);
    #1 start = 1'b0;

    // Wait for idle, then back-to-back with start held high
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!busy) begin
        ok = 1'b1;
        break;
      end
    end
    chk("idle_timeout", 32'(ok), 32'd1);
    @(negedge clk);
    start = 1'b1;
    a     = 8'h10;
    b     = 8'h20;
    t0    = -1;
    t1    = -1;
    for (cyc = 0; cyc < 40; cyc++) begin
      @(negedge clk);
      if (done) begin
        chk("b2b_diff", 32'(diff), 32'h0F0);
        chk("b2b_borrow", 32'(borrow_out), 32'd1);
        if (t0 < 0) t0 = cyc;
        else begin
          t1 = cyc;
          break;
        end
      end
    end
    start = 1'b0;
    chk("b2b_seen", 32'(t1 >= 0), 32'd1);
    chk("b2b_period", 32'(t1 - t0), 32'(W + 2));
    repeat (W + 4) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
